// File: rtl/frame_header_inserter.sv
// frame_header_inserter
// Prefixes every upstream frame with one header word.
// The header holds 8'hA5, an 8-bit frame sequence number and FRAME_SIZE.
// All outputs come from a single output register.
// A header costs one input bubble per frame.
//
// Optional feature: define FRAME_LEN_CHECK_EN to enable the payload length
// checker. frame_err then pulses for one cycle when a frame is not
// FRAME_SIZE words long. Without the macro, frame_err is tied to 0.
//
// Handshake: a word moves on a port only in a cycle where that port's valid and
// ready are both 1 at the rising edge. m_axis_tdata/m_axis_tlast hold stable
// while m_axis_tvalid=1 and m_axis_tready=0. s_axis_tready never depends on
// s_axis_tvalid. The output register is "free" when it is empty or being
// drained this cycle.
module frame_header_inserter #(
    parameter int FRAME_SIZE = 64,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic                  frame_err,
    output logic                  debug_state
);

    typedef enum logic {
        IDLE    = 1'b0,
        PAYLOAD = 1'b1
    } state_t;

    localparam logic [15:0] FRAME_SIZE_16 = 16'(FRAME_SIZE);

    state_t                state, state_nxt;
    logic [7:0]            seq, seq_nxt;
    logic [DATA_WIDTH-1:0] out_data, out_data_nxt;
    logic                  out_valid, out_valid_nxt;
    logic                  out_last, out_last_nxt;
    logic                  s_ready_c;
    logic                  slot_free;
    logic [DATA_WIDTH-1:0] header_word;

    assign slot_free     = !out_valid || m_axis_tready;
    // Gated by reset so that upstream never sees ready while a reset is in flight.
    assign s_axis_tready = s_ready_c && !reset;
    assign m_axis_tdata  = out_data;
    assign m_axis_tvalid = out_valid;
    assign m_axis_tlast  = out_last;
    assign debug_state   = state;

    // Build the header from the current sequence number; upper bits stay zero.
    always_comb begin
        header_word        = '0;
        header_word[31:0]  = {8'hA5, seq, FRAME_SIZE_16};
    end

    // Next-state and output-register logic.
    always_comb begin
        state_nxt     = state;
        seq_nxt       = seq;
        out_data_nxt  = out_data;
        out_valid_nxt = out_valid;
        out_last_nxt  = out_last;
        s_ready_c     = 1'b0;

        // A drained word empties the register unless something reloads it below.
        if (out_valid && m_axis_tready) begin
            out_valid_nxt = 1'b0;
        end

        case (state)
            IDLE: begin
                // Upstream word is held back while the header goes out first.
                if (s_axis_tvalid && slot_free) begin
                    out_data_nxt  = header_word;
                    out_valid_nxt = 1'b1;
                    out_last_nxt  = 1'b0;
                    state_nxt     = PAYLOAD;
                end
            end
            PAYLOAD: begin
                s_ready_c = slot_free;
                if (s_axis_tvalid && slot_free) begin
                    out_data_nxt  = s_axis_tdata;
                    out_last_nxt  = s_axis_tlast;
                    out_valid_nxt = 1'b1;
                    if (s_axis_tlast) begin
                        seq_nxt   = seq + 8'd1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, sequence number and output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            seq       <= 8'd0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            state     <= state_nxt;
            seq       <= seq_nxt;
            out_data  <= out_data_nxt;
            out_valid <= out_valid_nxt;
            out_last  <= out_last_nxt;
        end
    end

`ifdef FRAME_LEN_CHECK_EN
    localparam int             CNT_W    = $clog2(FRAME_SIZE) + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_SIZE - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [CNT_W-1:0] pay_cnt;
    logic             err_q;
    logic             in_xfer;

    assign in_xfer   = s_axis_tvalid && s_axis_tready;
    assign frame_err = err_q;

    // Count payload words per frame. An overlong frame is flagged once, at
    // index FRAME_SIZE-1. Its later tlast is not flagged again.
    always_ff @(posedge clk) begin
        if (reset) begin
            pay_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (in_xfer) begin
                if (s_axis_tlast) begin
                    pay_cnt <= '0;
                    if (pay_cnt < LAST_IDX) begin
                        err_q <= 1'b1;
                    end
                end else begin
                    if (pay_cnt == LAST_IDX) begin
                        err_q <= 1'b1;
                    end
                    if (pay_cnt != CNT_MAX) begin
                        pay_cnt <= pay_cnt + 1'b1;
                    end
                end
            end
        end
    end
`else
    assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_frame_header_inserter.sv
// Directed testbench for frame_header_inserter (FRAME_SIZE=64, DATA_WIDTH=32).
// Expected output words are pushed into a queue per frame and popped on each
// output transfer; frame_err pulses are counted and compared per test group.
module tb_frame_header_inserter;
    localparam int W = 33;  // {tlast, tdata}

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tlast;
    logic        s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tready;
    logic        frame_err;
    logic        debug_state;

    logic [W-1:0] exp_q[$];
    logic [7:0]   exp_seq;
    int           total = 0;
    int           bad = 0;
    int           err_pulses = 0;
    int           exp_pulses = 0;
    bit           tog = 1'b0;
    bit           prev_stall = 1'b0;
    logic [W-1:0] prev_word = '0;
    logic         xf;

    frame_header_inserter #(.FRAME_SIZE(64), .DATA_WIDTH(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .frame_err     (frame_err),
        .debug_state   (debug_state)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int exp_err(input int len);
`ifdef FRAME_LEN_CHECK_EN
        return (len == 64) ? 0 : 1;
`else
        return 0;
`endif
    endfunction

    // One cycle: drive after the falling edge, sample 1 time unit later,
    // score any output transfer that the next rising edge will perform.
    task automatic step(input logic rst_i, input logic sv, input logic [31:0] d,
                        input logic l, input logic mr, output logic in_x);
        logic [W-1:0] got;
        @(negedge clk);
        reset         = rst_i;
        s_axis_tvalid = sv;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        m_axis_tready = mr;
        #1;
        got = {m_axis_tlast, m_axis_tdata};
        if (prev_stall) check("stall_hold", 64'(got), 64'(prev_word));
        if (frame_err === 1'b1) err_pulses++;
        if (!rst_i && m_axis_tvalid && mr) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_word", 64'(got), 64'h1_DEAD_BEEF);
            end else begin
                check("out_word", 64'(got), 64'(exp_q.pop_front()));
            end
        end
        prev_stall = !rst_i && m_axis_tvalid && !mr;
        prev_word  = got;
        in_x       = sv && s_axis_tready && !rst_i;
    endtask

    // Send n_send words of a len-word frame. tlast is set only if the frame completes.
    task automatic send_frame(input int len, input int n_send, input logic [31:0] base,
                              input bit tog_ready, input bit rand_valid, input bit chk_cycles);
        int   sent = 0;
        int   cyc = 0;
        bit   pres = 1'b0;
        logic x;
        logic mr;
        exp_q.push_back({1'b0, 8'hA5, exp_seq, 16'h0040});
        for (int i = 0; i < n_send; i++) exp_q.push_back({(i == len - 1), base + 32'(i)});
        if (n_send == len) exp_seq = exp_seq + 8'd1;
        while (sent < n_send && cyc < len * 4 + 40) begin
            if (!pres) pres = rand_valid ? ($urandom_range(0, 1) == 1) : 1'b1;
            mr  = tog_ready ? tog : 1'b1;
            tog = !tog;
            step(1'b0, pres, base + 32'(sent), (sent == len - 1), mr, x);
            cyc++;
            if (x) begin
                sent++;
                pres = 1'b0;
            end
        end
        check("frame_words_accepted", 64'(sent), 64'(n_send));
        if (chk_cycles) check("frame_cycles", 64'(cyc), 64'(len + 1));
    endtask

    task automatic drain();
        int   n = 0;
        logic x;
        while (exp_q.size() > 0 && n < 300) begin
            step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, x);
            n++;
        end
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, x);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, x);
        check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        reset = 1'b1; s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tlast = 1'b0;
        m_axis_tready = 1'b0; exp_seq = 8'd0;

        // Reset: values after two reset edges, sampled during a third reset cycle
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, xf);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, xf);
        step(1'b1, 1'b1, 32'h0, 1'b0, 1'b1, xf);
        check("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_m_tlast",  64'(m_axis_tlast),  64'd0);
        check("rst_m_tdata",  64'(m_axis_tdata),  64'd0);
        check("rst_frame_err", 64'(frame_err),    64'd0);
        check("rst_s_tready", 64'(s_axis_tready), 64'd0);
        check("rst_state",    64'(debug_state),   64'd0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, xf);
        check("post_rst_s_tready", 64'(s_axis_tready), 64'd0);

        // 64-word frame, data 0..63, downstream always ready: 65 output words
        err_pulses = 0;
        send_frame(64, 64, 32'd0, 1'b0, 1'b0, 1'b1);
        drain();
        check("frame_err_64", 64'(err_pulses), 64'(exp_err(64)));

        // Three back-to-back frames: headers seq 1,2,3, one bubble each
        err_pulses = 0;
        send_frame(64, 64, 32'h1000, 1'b0, 1'b0, 1'b1);
        send_frame(64, 64, 32'h2000, 1'b0, 1'b0, 1'b1);
        send_frame(64, 64, 32'h3000, 1'b0, 1'b0, 1'b1);
        drain();
        check("frame_err_b2b", 64'(err_pulses), 64'd0);

        // Toggling downstream ready with random upstream valid
        err_pulses = 0;
        send_frame(64, 64, 32'h4000, 1'b1, 1'b1, 1'b0);
        send_frame(10, 10, 32'h5000, 1'b1, 1'b1, 1'b0);
        send_frame(1,  1,  32'h6000, 1'b1, 1'b1, 1'b0);
        drain();
        check("frame_err_stall", 64'(err_pulses), 64'(exp_err(64) + exp_err(10) + exp_err(1)));

        // Sequence wrap: 252 two-word frames take seq from 7 through 255 to 2
        err_pulses = 0;
        exp_pulses = 0;
        for (int f = 0; f < 252; f++) begin
            send_frame(2, 2, 32'h7000 + 32'(f * 16), 1'b0, 1'b0, 1'b1);
            exp_pulses += exp_err(2);
        end
        drain();
        check("seq_after_wrap", 64'(exp_seq), 64'h03);
        check("frame_err_wrap", 64'(err_pulses), 64'(exp_pulses));

        // Length errors: short 10-word and overlong 70-word frames
        err_pulses = 0;
        send_frame(10, 10, 32'h8000, 1'b0, 1'b0, 1'b1);
        drain();
        check("frame_err_len10", 64'(err_pulses), 64'(exp_err(10)));
        err_pulses = 0;
        send_frame(70, 70, 32'h9000, 1'b0, 1'b0, 1'b1);
        drain();
        check("frame_err_len70", 64'(err_pulses), 64'(exp_err(70)));

        // Reset after word 20 of a frame; next header restarts at seq 0
        send_frame(64, 21, 32'hA000, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, xf);
        check("midrst_s_tready", 64'(s_axis_tready), 64'd0);
        exp_q.delete();
        exp_seq    = 8'd0;
        prev_stall = 1'b0;
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, xf);
        check("midrst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("midrst_m_tdata",  64'(m_axis_tdata),  64'd0);
        check("midrst_state",    64'(debug_state),   64'd0);
        err_pulses = 0;
        send_frame(5, 5, 32'hB000, 1'b0, 1'b0, 1'b1);
        drain();
        check("frame_err_after_rst", 64'(err_pulses), 64'(exp_err(5)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
